axi_burst_mem: RTL

//  AXI4 slave memory that terminates the L2 cache's AXI master port. It is used in simulation and as the FPGA on-chip DDR substitute.

---
 rtl/axi_burst_mem_pkg.sv | 7 +
 rtl/axi_burst_mem_if.sv | 37 +++
 rtl/axi_burst_mem_ram.sv | 21 ++
 rtl/axi_burst_mem.sv | 95 +++++++++
 4 files changed

// File: rtl/axi_burst_mem_pkg.sv
// axi_burst_mem_pkg: shared FSM encodings, response codes and AXI length width
package axi_burst_mem_pkg;
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int AXI_LEN_W = 8;
endpackage

// File: rtl/axi_burst_mem_if.sv
// axi_burst_mem_if: AXI4 AW/W/B/AR/R channel bundle with master/slave views
interface axi_burst_mem_if
  import axi_burst_mem_pkg::*;
#(
  parameter int AXI_ID_W = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
);
  logic [AXI_ID_W-1:0] awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0] awlen;
  logic awvalid, awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [AXI_ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [AXI_ID_W-1:0] arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_LEN_W-1:0] arlen;
  logic arvalid, arready;
  logic [AXI_ID_W-1:0] rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  modport slave (
    input awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_mem_ram.sv
// axi_burst_mem_ram: single-port synchronous RAM with byte write enables and registered read data
module axi_burst_mem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/axi_burst_mem.sv
// axi_burst_mem: AXI4 INCR-burst slave memory, one outstanding transaction, 2-entry read skid buffer
module axi_burst_mem
  import axi_burst_mem_pkg::*;
#(
  parameter int AXI_ID_W = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 16
) (
  input logic clk,
  input logic rst,
  axi_burst_mem_if.slave s
);
  localparam int STRB_W = AXI_DATA_W/8;
  localparam int OFF = $clog2(STRB_W);
  state_t state, state_n;
  logic [MEM_ADDR_W-1:0] addr;
  logic [AXI_LEN_W-1:0] len;
  logic [AXI_LEN_W:0] cnt, ocnt;
  logic [AXI_ID_W-1:0] id;
  logic err, wr_turn, pv;
  logic [1:0] occ;
  logic [AXI_DATA_W-1:0] b0, b1, rd;
  logic aw_hs, ar_hs, w_hs, w_fin, issue, pop, r_fin;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    aw_hs = state == IDLE && s.awvalid && (wr_turn || !s.arvalid);
    ar_hs = state == IDLE && s.arvalid && (!wr_turn || !s.awvalid);
    w_hs = state == WDATA && s.wvalid;
    w_fin = w_hs && cnt == {1'b0, len};
    pop = occ != 2'd0 && s.rready;
    r_fin = pop && ocnt == {1'b0, len};
    // a new read may only launch if its data is guaranteed a buffer slot two edges later
    issue = state == RDATA && cnt <= {1'b0, len} && ({1'b0, occ} + {2'b0, pv} - {2'b0, pop}) <= 3'd1;
    state_n = aw_hs ? WDATA : ar_hs ? RDATA : w_fin ? WRESP :
              ((state == WRESP && s.bready) || r_fin) ? IDLE : state;
    s.awready = !rst && state == IDLE && (wr_turn || !s.arvalid);
    s.arready = !rst && state == IDLE && (!wr_turn || !s.awvalid);
    s.wready = state == WDATA;
    s.bvalid = state == WRESP;
    s.bresp = (state == WRESP && err) ? RESP_SLVERR : RESP_OKAY;
    s.bid = id;
    s.rid = id;
    s.rdata = b0;
    s.rvalid = occ != 2'd0;
    s.rlast = occ != 2'd0 && ocnt == {1'b0, len};
    s.rresp = RESP_OKAY;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      len <= '0;
      cnt <= '0;
      ocnt <= '0;
      id <= '0;
      err <= 1'b0;
      wr_turn <= 1'b1;
      pv <= 1'b0;
      occ <= 2'd0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      if (aw_hs || ar_hs) begin
        addr <= aw_hs ? s.awaddr[MEM_ADDR_W+OFF-1:OFF] : s.araddr[MEM_ADDR_W+OFF-1:OFF];
        len <= aw_hs ? s.awlen : s.arlen;
        id <= aw_hs ? s.awid : s.arid;
        cnt <= '0;
        ocnt <= '0;
        err <= 1'b0;
        wr_turn <= ar_hs;
      end
      if (w_hs || issue) begin
        addr <= addr + MEM_ADDR_W'(1);
        cnt <= cnt + 9'd1;
      end
      if (w_hs) err <= err | (s.wlast != w_fin);
      if (pop) ocnt <= ocnt + 9'd1;
      pv <= issue;
      occ <= occ + {1'b0, pv} - {1'b0, pop};
      b0 <= pop ? (occ == 2'd2 ? b1 : rd) : ((occ == 2'd0 && pv) ? rd : b0);
      if (pv && (occ == 2'd2 || (occ == 2'd1 && !pop))) b1 <= rd;
    end
  end
  axi_burst_mem_ram #(.DATA_W(AXI_DATA_W), .ADDR_W(MEM_ADDR_W)) u_ram (
    .clk(clk),
    .en(w_hs || issue),
    .we(w_hs ? s.wstrb : '0),
    .addr(addr),
    .wdata(s.wdata),
    .rdata(rd)
  );
endmodule
